// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end and its consumers:
//   - fetchState_t : fetch sequencer state encoding
//   - fetchEntry_t : one buffered fetch result {pc, instr, err} at the
//                    default 32-bit PC width
//   - FETCH_TRAP_VECTOR : default trap entry PC (.ktext base)
//   - FETCH_NOP    : canonical NOP (addi x0, x0, 0) that downstream stages
//                    inject when the fetch queue is empty or flushed
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one cycle of settling after reset release
    S_REQ  = 2'd1,  // presenting a request, waiting for grant
    S_WAIT = 2'd2,  // one request outstanding, waiting for its response
    S_DROP = 2'd3   // one stale request outstanding; its response is dropped
  } fetchState_t;

  localparam int unsigned FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  err;
  } fetchEntry_t;

  localparam logic [31:0] FETCH_TRAP_VECTOR = 32'h8000_0000;
  localparam logic [31:0] FETCH_NOP         = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Pointer/count FIFO with synchronous clear. Shared by the fetch front end
// and the decode stage.
//
// Parameters:
//   DEPTH  number of entries, power of two, >= 2
//   WIDTH  entry width in bits
//
// Ports:
//   iCLK       clock
//   iRST       asynchronous active-high reset, empties the FIFO
//   iClear     synchronous clear; wins over a push or pop in the same cycle
//   iPush      write iPushData at the tail (ignored when full unless a pop
//              happens in the same cycle)
//   iPushData  data to write
//   iPop       drop the head entry (ignored when empty)
//   oHeadData  head entry, meaningful only while oEmpty is low
//   oEmpty     no entries stored
//   oFull      DEPTH entries stored
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iClear,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oHeadData,
  output logic             oEmpty,
  output logic             oFull
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign oEmpty = (count == '0);
  assign oFull  = (count == CW'(DEPTH));

  // A pop frees the slot the push needs, so push-while-full is legal when a
  // pop happens in the same cycle. A pop on an empty FIFO is a no-op, so a
  // push+pop into an empty FIFO just stores the new word.
  assign doPop  = iPop & ~oEmpty;
  assign doPush = iPush & (~oFull | doPop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and updates together.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iClear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // NOTE: the storage array is deliberately not reset; a slot is only read
  // after a push has written it, as tracked by count.
  always_ff @(posedge iCLK) begin
    if (doPush && !iClear) mem[wrPtr] <= iPushData;
  end

  assign oHeadData = mem[rdPtr];

endmodule : fetch_fifo

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
// Instruction-fetch front end for the pipelined core. Issues one request at
// a time on a wait-state-capable instruction bus and buffers each returned
// word together with its PC and bus-error flag in a DEPTH-entry prefetch
// FIFO. Redirects (branch/jump/eret) and trap entry flush the FIFO and
// restart fetching; a response already in flight is discarded.
//
// Parameters:
//   XLEN         PC / address width
//   DEPTH        prefetch FIFO entries, power of two, >= 2
//   TRAP_VECTOR  PC loaded on iTrap
//
// Ports:
//   iCLK, iRST      clock; asynchronous active-high reset
//   iInitialPC      PC loaded (word aligned) while iRST is high
//   oIReadEnable    bus request valid
//   oIAddress       request address (word aligned); always shows fetchPc
//   iIGrant         request accepted this cycle
//   iIValid         response valid
//   iIReadData      response instruction word
//   iIError         response carries a bus error
//   oInstrValid     FIFO head valid
//   oInstr          head instruction (0 when empty)
//   oInstrPC        head PC (0 when empty)
//   oInstrErr       head carries a bus error (0 when empty)
//   iInstrReady     consumer pops the head while oInstrValid is high
//   iRedirect       flush and restart at iRedirectPC (bits [1:0] ignored)
//   iRedirectPC     redirect target
//   iTrap           flush and restart at TRAP_VECTOR; wins over iRedirect
// ---------------------------------------------------------------------------
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(FETCH_TRAP_VECTOR)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iInitialPC,
  output logic            oIReadEnable,
  output logic [XLEN-1:0] oIAddress,
  input  logic            iIGrant,
  input  logic            iIValid,
  input  logic [31:0]     iIReadData,
  input  logic            iIError,
  output logic            oInstrValid,
  output logic [31:0]     oInstr,
  output logic [XLEN-1:0] oInstrPC,
  output logic            oInstrErr,
  input  logic            iInstrReady,
  input  logic            iRedirect,
  input  logic [XLEN-1:0] iRedirectPC,
  input  logic            iTrap
);

  // FIFO entry layout: {pc, instr, err}
  localparam int unsigned ENTRY_W = XLEN + 32 + 1;

  fetchState_t      state;
  fetchState_t      stateNext;
  logic [XLEN-1:0]  fetchPc;
  logic [XLEN-1:0]  fetchPcNext;
  logic [XLEN-1:0]  reqPc;
  logic [XLEN-1:0]  flushTarget;
  logic             flush;
  logic             readEn;
  logic             grantTaken;
  logic             push;
  logic             pop;
  logic             fifoEmpty;
  logic             fifoFull;
  logic [ENTRY_W-1:0] pushData;
  logic [ENTRY_W-1:0] headData;

  // The low PC bits are architecturally zero for 32-bit instructions.
  logic unusedPcBits;
  assign unusedPcBits = ^{iInitialPC[1:0], iRedirectPC[1:0]};

  // Trap entry outranks an ordinary redirect raised in the same cycle.
  assign flush       = iTrap | iRedirect;
  assign flushTarget = iTrap ? TRAP_VECTOR : {iRedirectPC[XLEN-1:2], 2'b00};

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= S_IDLE;
      fetchPc <= {iInitialPC[XLEN-1:2], 2'b00};
      reqPc   <= '0;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      if (grantTaken) reqPc <= fetchPc;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and bus handshake
  // ------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first so that no
  // path through the case statement can infer a latch.
  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    readEn      = 1'b0;
    grantTaken  = 1'b0;
    push        = 1'b0;

    unique case (state)
      S_IDLE: begin
        stateNext = S_REQ;
      end

      S_REQ: begin
        // Only one request is ever outstanding, so a free slot now is the
        // slot its response will land in: the request reserves it.
        readEn     = ~fifoFull;
        grantTaken = readEn & iIGrant;
        if (grantTaken) begin
          fetchPcNext = fetchPc + XLEN'(4);
          // A grant that coincides with a flush still owes us a response;
          // it belongs to the old path and must be swallowed.
          stateNext   = flush ? S_DROP : S_WAIT;
        end
      end

      S_WAIT: begin
        if (iIValid) begin
          push      = ~flush;
          stateNext = S_REQ;
        end else if (flush) begin
          stateNext = S_DROP;
        end
      end

      S_DROP: begin
        // A further flush only retargets fetchPc; the single stale response
        // is still the one to discard.
        if (iIValid) stateNext = S_REQ;
      end

      default: begin
        stateNext = S_IDLE;
      end
    endcase

    if (flush) fetchPcNext = flushTarget;
  end

  // ------------------------------------------------------------------------
  // Prefetch FIFO
  // ------------------------------------------------------------------------
  assign pushData = {reqPc, iIReadData, iIError};
  assign pop      = iInstrReady & ~fifoEmpty & ~flush;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iClear    (flush),
    .iPush     (push),
    .iPushData (pushData),
    .iPop      (pop),
    .oHeadData (headData),
    .oEmpty    (fifoEmpty),
    .oFull     (fifoFull)
  );

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign oIReadEnable = readEn;
  assign oIAddress    = fetchPc;
  assign oInstrValid  = ~fifoEmpty;

  // Head fields read as zero when nothing is buffered, so the unwritten
  // storage never reaches the consumer.
  assign {oInstrPC, oInstr, oInstrErr} = fifoEmpty ? '0 : headData;

endmodule : fetch_prefetch_unit

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
// Directed bench for fetch_prefetch_unit (XLEN=32, DEPTH=4).
// A bus responder grants requests (optionally stalling one address or
// limiting the number of grants) and answers one cycle after each grant with
// the word {16'hC0DE, addr[15:0]}, flagging an error for one chosen address.
// A monitor records every granted address and every popped head entry.
// Timing: the bench drives at the falling edge, the responder updates 1 ns
// after the rising edge, the monitor samples 3 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [31:0] iInitialPC;
  logic        oIReadEnable;
  logic [31:0] oIAddress;
  logic        iIGrant;
  logic        iIValid;
  logic [31:0] iIReadData;
  logic        iIError;
  logic        oInstrValid;
  logic [31:0] oInstr;
  logic [31:0] oInstrPC;
  logic        oInstrErr;
  logic        iInstrReady;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        iTrap;

  int checks = 0;
  int errors = 0;

  // Bench configuration (written by the test sequence only)
  logic        busOn;
  int          grantLimit;
  logic [31:0] stallAddr;
  int          stallCycles;
  logic [31:0] errAddr;

  // Responder state (written by the responder only)
  logic        pending;
  logic [31:0] pendAddr;
  int          grantCount;
  int          stallSeen;

  // Monitor state (written by the monitor only)
  logic [31:0] grantQ[$];
  fetchEntry_t popQ[$];
  fetchEntry_t monEntry;

  fetch_prefetch_unit dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iInitialPC   (iInitialPC),
    .oIReadEnable (oIReadEnable),
    .oIAddress    (oIAddress),
    .iIGrant      (iIGrant),
    .iIValid      (iIValid),
    .iIReadData   (iIReadData),
    .iIError      (iIError),
    .oInstrValid  (oInstrValid),
    .oInstr       (oInstr),
    .oInstrPC     (oInstrPC),
    .oInstrErr    (oInstrErr),
    .iInstrReady  (iInstrReady),
    .iRedirect    (iRedirect),
    .iRedirectPC  (iRedirectPC),
    .iTrap        (iTrap)
  );

  always #5 iCLK = ~iCLK;

  // Bus responder
  initial begin
    iIGrant = 1'b0; iIValid = 1'b0; iIError = 1'b0; iIReadData = '0;
    pending = 1'b0; pendAddr = '0; grantCount = 0; stallSeen = 0;
    forever begin
      @(posedge iCLK);
      #1;
      iIGrant = 1'b0;
      iIValid = 1'b0;
      iIError = 1'b0;
      if (iRST) begin
        pending    = 1'b0;
        grantCount = 0;
        stallSeen  = 0;
      end else if (pending) begin
        iIValid    = 1'b1;
        iIReadData = {16'hC0DE, pendAddr[15:0]};
        iIError    = (pendAddr == errAddr);
        pending    = 1'b0;
      end else if (busOn && oIReadEnable && grantCount < grantLimit) begin
        if (oIAddress == stallAddr && stallSeen < stallCycles) begin
          stallSeen++;
        end else begin
          iIGrant  = 1'b1;
          pending  = 1'b1;
          pendAddr = oIAddress;
          grantCount++;
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge iCLK);
      #3;
      if (iRST) begin
        grantQ.delete();
        popQ.delete();
      end else begin
        if (oIReadEnable && iIGrant) grantQ.push_back(oIAddress);
        if (iInstrReady && oInstrValid && !iRedirect && !iTrap) begin
          monEntry.pc    = oInstrPC;
          monEntry.instr = oInstr;
          monEntry.err   = oInstrErr;
          popQ.push_back(monEntry);
        end
      end
    end
  end

  task automatic defaults();
    busOn       = 1'b0;
    grantLimit  = 1000;
    stallAddr   = 32'hFFFF_FFFF;
    stallCycles = 0;
    errAddr     = 32'hFFFF_FFFF;
    iInstrReady = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPC = '0;
    iTrap       = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge iCLK);
    iInitialPC = pc;
    iRST       = 1'b1;
    repeat (2) @(negedge iCLK);
    iRST  = 1'b0;
    busOn = 1'b1;
  endtask

  task automatic test_reset();
    defaults();
    @(negedge iCLK);
    iInitialPC = 32'h0040_0001;
    iRST = 1'b1;
    @(negedge iCLK);
    checks++;
    if ({oIReadEnable, oInstrValid, oInstr, oInstrPC, oInstrErr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b v=%b i=%h pc=%h e=%b want all 0",
               oIReadEnable, oInstrValid, oInstr, oInstrPC, oInstrErr);
    end
    checks++;
    if (oIAddress !== 32'h0040_0000) begin
      errors++;
      $display("FAIL reset_address got %h want 00400000", oIAddress);
    end
    @(negedge iCLK);
    iRST  = 1'b0;
    busOn = 1'b1;
    #1;
    checks++;
    if (oIReadEnable !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle_idle got rd=%b want 0", oIReadEnable);
    end
    @(negedge iCLK);
    checks++;
    if ({oIReadEnable, oIAddress} !== {1'b1, 32'h0040_0000}) begin
      errors++;
      $display("FAIL first_request got rd=%b addr=%h want 1 00400000", oIReadEnable, oIAddress);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] expPc[3];
    expPc = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
    defaults();
    do_reset(32'h0040_0000);
    iInstrReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (popQ.size() >= 3) break;
      @(negedge iCLK);
    end
    checks++;
    if (popQ.size() < 3) begin
      errors++;
      $display("FAIL seq_timeout got %0d pops want 3", popQ.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (grantQ[i] !== expPc[i] || popQ[i].pc !== expPc[i]) begin
        errors++;
        $display("FAIL seq_pc[%0d] got req=%h pc=%h want %h", i, grantQ[i], popQ[i].pc, expPc[i]);
      end
    end
    checks++;
    if (popQ[0].instr !== 32'hC0DE_0000 || popQ[2].instr !== 32'hC0DE_0008) begin
      errors++;
      $display("FAIL seq_instr got %h %h want c0de0000 c0de0008", popQ[0].instr, popQ[2].instr);
    end
  endtask

  task automatic test_fill();
    defaults();
    do_reset(32'h0040_0000);
    repeat (30) @(negedge iCLK);
    checks++;
    if (grantQ.size() != 4 || oIReadEnable !== 1'b0) begin
      errors++;
      $display("FAIL fill_stop got grants=%0d rd=%b want 4 0", grantQ.size(), oIReadEnable);
    end
    checks++;
    if ({oInstrValid, oInstrPC} !== {1'b1, 32'h0040_0000}) begin
      errors++;
      $display("FAIL fill_head got v=%b pc=%h want 1 00400000", oInstrValid, oInstrPC);
    end
    iInstrReady = 1'b1;
    @(negedge iCLK);
    iInstrReady = 1'b0;
    repeat (12) @(negedge iCLK);
    checks++;
    if (popQ.size() != 1 || grantQ.size() != 5) begin
      errors++;
      $display("FAIL fill_refill_count got pops=%0d grants=%0d want 1 5", popQ.size(), grantQ.size());
    end
    checks++;
    if (grantQ[4] !== 32'h0040_0010) begin
      errors++;
      $display("FAIL fill_refill_addr got %h want 00400010", grantQ[4]);
    end
    checks++;
    if ({oIReadEnable, oInstrPC} !== {1'b0, 32'h0040_0004}) begin
      errors++;
      $display("FAIL fill_after_pop got rd=%b pc=%h want 0 00400004", oIReadEnable, oInstrPC);
    end
  endtask

  task automatic test_stall();
    defaults();
    stallAddr   = 32'h0040_0004;
    stallCycles = 3;
    grantLimit  = 2;
    do_reset(32'h0040_0000);
    for (int i = 0; i < 50; i++) begin
      if (oIReadEnable && oIAddress == 32'h0040_0004) break;
      @(negedge iCLK);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({oIReadEnable, oIAddress} !== {1'b1, 32'h0040_0004}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got rd=%b addr=%h want 1 00400004", i, oIReadEnable, oIAddress);
      end
      @(negedge iCLK);
    end
    repeat (10) @(negedge iCLK);
    iInstrReady = 1'b1;
    repeat (8) @(negedge iCLK);
    checks++;
    if (popQ.size() != 2) begin
      errors++;
      $display("FAIL stall_pushes got %0d want 2", popQ.size());
    end
    checks++;
    if (popQ[1].pc !== 32'h0040_0004 || popQ[1].instr !== 32'hC0DE_0004) begin
      errors++;
      $display("FAIL stall_word got pc=%h i=%h want 00400004 c0de0004", popQ[1].pc, popQ[1].instr);
    end
  endtask

  task automatic test_redirect();
    int pBase;
    int gBase;
    defaults();
    do_reset(32'h0040_0000);
    iInstrReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (oIReadEnable && iIGrant && oIAddress == 32'h0040_000C) break;
      @(negedge iCLK);
    end
    checks++;
    if (!(oIReadEnable && iIGrant && oIAddress == 32'h0040_000C)) begin
      errors++;
      $display("FAIL redir_setup got rd=%b addr=%h want 1 0040000c", oIReadEnable, oIAddress);
    end
    pBase       = popQ.size();
    iRedirect   = 1'b1;
    iRedirectPC = 32'h0040_0103;
    @(negedge iCLK);
    iRedirect = 1'b0;
    gBase     = grantQ.size();
    checks++;
    if ({oInstrValid, oIAddress} !== {1'b0, 32'h0040_0100}) begin
      errors++;
      $display("FAIL redir_flush got v=%b addr=%h want 0 00400100", oInstrValid, oIAddress);
    end
    for (int i = 0; i < 50; i++) begin
      if (popQ.size() > pBase) break;
      @(negedge iCLK);
    end
    checks++;
    if (popQ[pBase].pc !== 32'h0040_0100 || grantQ[gBase] !== 32'h0040_0100) begin
      errors++;
      $display("FAIL redir_target got pc=%h req=%h want 00400100", popQ[pBase].pc, grantQ[gBase]);
    end
  endtask

  task automatic test_trap();
    int pBase;
    int gBase;
    defaults();
    do_reset(32'h0040_0000);
    iInstrReady = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (popQ.size() >= 1) break;
      @(negedge iCLK);
    end
    iTrap       = 1'b1;
    iRedirect   = 1'b1;
    iRedirectPC = 32'h0040_0200;
    @(negedge iCLK);
    iTrap     = 1'b0;
    iRedirect = 1'b0;
    gBase     = grantQ.size();
    pBase     = popQ.size();
    checks++;
    if ({oInstrValid, oIAddress} !== {1'b0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL trap_flush got v=%b addr=%h want 0 80000000", oInstrValid, oIAddress);
    end
    for (int i = 0; i < 50; i++) begin
      if (popQ.size() > pBase) break;
      @(negedge iCLK);
    end
    checks++;
    if (popQ[pBase].pc !== 32'h8000_0000 || grantQ[gBase] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL trap_target got pc=%h req=%h want 80000000", popQ[pBase].pc, grantQ[gBase]);
    end
  endtask

  task automatic test_error();
    defaults();
    errAddr    = 32'h0040_0008;
    grantLimit = 4;
    do_reset(32'h0040_0000);
    repeat (20) @(negedge iCLK);
    iInstrReady = 1'b1;
    repeat (10) @(negedge iCLK);
    checks++;
    if (popQ.size() != 4) begin
      errors++;
      $display("FAIL err_count got %0d want 4", popQ.size());
    end
    checks++;
    if (popQ[2].pc !== 32'h0040_0008 || popQ[2].err !== 1'b1 || popQ[2].instr !== 32'hC0DE_0008) begin
      errors++;
      $display("FAIL err_entry got pc=%h e=%b i=%h want 00400008 1 c0de0008",
               popQ[2].pc, popQ[2].err, popQ[2].instr);
    end
    checks++;
    if (popQ[3].pc !== 32'h0040_000C || popQ[3].err !== 1'b0 || popQ[1].err !== 1'b0) begin
      errors++;
      $display("FAIL err_neighbours got pc=%h e3=%b e1=%b want 0040000c 0 0",
               popQ[3].pc, popQ[3].err, popQ[1].err);
    end
  endtask

  task automatic test_wrap();
    defaults();
    do_reset(32'hFFFF_FFF8);
    iInstrReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (popQ.size() >= 3) break;
      @(negedge iCLK);
    end
    checks++;
    if (grantQ[1] !== 32'hFFFF_FFFC || grantQ[2] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_req got %h %h want fffffffc 00000000", grantQ[1], grantQ[2]);
    end
    checks++;
    if (popQ[1].pc !== 32'hFFFF_FFFC || popQ[2].pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_pc got %h %h want fffffffc 00000000", popQ[1].pc, popQ[2].pc);
    end
  endtask

  initial begin
    iInitialPC = '0;
    defaults();
    test_reset();
    test_sequential();
    test_fill();
    test_stall();
    test_redirect();
    test_trap();
    test_error();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_prefetch_unit

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) RISC-V core.
- Replaces the single-cycle core's combinational "PC drives the instruction bus" path.
- Issues requests on a wait-state-capable instruction bus and buffers returned words with their PCs in a DEPTH-entry prefetch FIFO.
- Handles redirects from branch/jump/eret and trap entry, discarding any in-flight response.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- TRAP_VECTOR, 32'h8000_0000, PC loaded on iTrap (.ktext base).

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset
- iInitialPC  in  XLEN  PC loaded while iRST is high
- oIReadEnable  out  1  bus request valid
- oIAddress  out  XLEN  request address, word aligned
- iIGrant  in  1  request accepted this cycle
- iIValid  in  1  response data valid
- iIReadData  in  32  response instruction word
- iIError  in  1  bus error qualifying iIValid
- oInstrValid  out  1  FIFO head valid
- oInstr  out  32  head instruction
- oInstrPC  out  XLEN  head PC
- oInstrErr  out  1  head carries a bus error
- iInstrReady  in  1  consumer pops head when oInstrValid is high
- iRedirect  in  1  flush and restart at iRedirectPC
- iRedirectPC  in  XLEN  redirect target; bits [1:0] ignored (forced 00)
- iTrap  in  1  flush and restart at TRAP_VECTOR

Behaviour:
- Reset: asynchronous, active-high iRST; clock iCLK.
  - While iRST is high: fetch_pc <= {iInitialPC[XLEN-1:2],2'b00}; FIFO empty; state S_IDLE.
  - While iRST is high, all outputs are 0 (oIAddress shows fetch_pc).
- States:
  - S_IDLE -> S_REQ unconditionally, one cycle after reset release.
  - S_REQ: oIReadEnable = (count + 0 < DEPTH), i.e. only when the FIFO has a free slot; oIAddress = fetch_pc.
    - On oIReadEnable & iIGrant: latch req_pc = fetch_pc, fetch_pc += 4 (mod 2^XLEN, wraps silently), go S_WAIT.
    - The address must stay stable while oIReadEnable is high and iIGrant is low, except on redirect/trap.
  - S_WAIT: oIReadEnable = 0.
    - On iIValid: push {req_pc, iIReadData, iIError}, go S_REQ.
    - A slot is guaranteed because S_REQ reserved it: the outstanding request counts as occupancy, and issue requires count + 1 <= DEPTH.
  - S_DROP: oIReadEnable = 0; the next iIValid is discarded, go S_REQ.
- Latency: grant in cycle N with response in cycle M puts the word on oInstrValid in cycle M+1. The minimum bus turnaround is 1 cycle.
- Throughput: at most one request outstanding, so at most one word per 2 cycles.
- FIFO: simultaneous push and pop are allowed at any count, including full and empty.
  - Push into an empty FIFO is visible the next cycle; there is no bypass.
  - Pop when empty is ignored.
- Redirect/trap, priority iRST > iTrap > iRedirect, effective at the sampling edge:
  - FIFO cleared; oInstrValid = 0 next cycle.
  - fetch_pc <= target.
  - From S_REQ without grant: stay S_REQ, new address next cycle.
  - From S_REQ with grant in the same cycle, or from S_WAIT without iIValid: go S_DROP.
  - From S_WAIT with iIValid in the same cycle: the word is discarded; go S_REQ.
  - From S_DROP: stay S_DROP with the new target.
  - A push or pop coinciding with a flush is discarded.
- Bus error: the word is delivered with oInstrErr = 1 and fetching continues sequentially. The consumer raises the exception.
- Reset mid-transaction: the state machine aborts. A bus response arriving after reset release, while in S_IDLE or S_REQ before grant, is ignored.

Decomposition:
- Package fetch_pkg holds:
  - state encoding S_IDLE/S_REQ/S_WAIT/S_DROP;
  - fetch-entry struct {pc, instr, err};
  - TRAP_VECTOR default;
  - NOP word 32'h0000_0013 for consumers.
- Sub-module fetch_fifo(DEPTH, WIDTH) provides the pointer/count FIFO with a synchronous clear input. It is reused later by the decode stage.

Test Plan:
- Reset with iInitialPC=32'h0040_0000, bus granting immediately with 1-cycle response -> requests go to 0x400000, 0x400004, 0x400008; oInstrPC follows the same sequence; oIReadEnable is 0 in the first post-reset cycle.
- iInstrReady=0 with DEPTH=4 -> exactly 4 grants, then oIReadEnable stays 0. Popping one entry -> exactly one new request, to 0x400010.
- iIGrant held low for 3 cycles -> oIAddress is stable at 0x400004 across the wait; exactly one push after grant + response.
- iRedirect with iRedirectPC=32'h0040_0103 in the same cycle as a grant for 0x40000C -> the 0x40000C response is dropped; the next request is 0x400100; the FIFO is empty the cycle after the redirect.
- iTrap and iRedirect asserted together -> the next request is 0x80000000.
- Response with iIError=1 for 0x400008 -> head shows oInstrErr=1 at PC 0x400008; the next entry is 0x40000C with err=0.
- fetch_pc=32'hFFFF_FFFC granted -> the next request address is 32'h0000_0000.
